// File: rtl/ram1kx18_arb_if.sv
// ram1kx18_arb_if: bundle of requester-side and RAM-side signals for ram1kx18_arb.
//   Requester side : req_valid/req_wen/req_lock (one bit per requester),
//                    req_addr (10 bits per requester), req_wdata (18 bits per requester),
//                    req_ready (one-hot grant), rsp_valid (one-hot), rsp_data (shared).
//   RAM side       : ram_wen, ram_addr, ram_wdata to the RAM; ram_rdata from the RAM.
// slave  : the arbiter's view.
// master : the environment's view (requesters plus RAM).
interface ram1kx18_arb_if #(
    parameter int unsigned NREQ = 3
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_wen;
    logic [NREQ-1:0]    req_lock;
    logic [NREQ*10-1:0] req_addr;
    logic [NREQ*18-1:0] req_wdata;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    rsp_valid;
    logic [17:0]        rsp_data;
    logic               ram_wen;
    logic [9:0]         ram_addr;
    logic [17:0]        ram_wdata;
    logic [17:0]        ram_rdata;

    modport slave (
        input  req_valid, req_wen, req_lock, req_addr, req_wdata, ram_rdata,
        output req_ready, rsp_valid, rsp_data, ram_wen, ram_addr, ram_wdata
    );

    modport master (
        output req_valid, req_wen, req_lock, req_addr, req_wdata, ram_rdata,
        input  req_ready, rsp_valid, rsp_data, ram_wen, ram_addr, ram_wdata
    );
endinterface

// File: rtl/ram1kx18_arb.sv
// ram1kx18_arb: round-robin arbiter sharing one single-port 1Kx18 RAM between NREQ requesters.
// At most one access is granted per cycle; read data returns to the granted requester one
// cycle later. A requester can hold the grant across a burst with req_lock.
//   mclk  : clock, all state on the rising edge
//   rst_n : asynchronous active-low reset; also forces all grant/RAM outputs low while asserted
//   bus   : ram1kx18_arb_if.slave, requester handshake plus RAM port
module ram1kx18_arb #(
    parameter int unsigned NREQ = 3
) (
    input logic            mclk,
    input logic            rst_n,
    ram1kx18_arb_if.slave  bus
);
    localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;
    typedef logic [IdxW-1:0] idx_t;

    idx_t            ptr_q, ptr_d;
    idx_t            lock_own_q, lock_own_d;
    logic            lock_act_q, lock_act_d;
    logic [NREQ-1:0] rsp_pend_q, rsp_pend_d;

    logic            gnt_found;
    idx_t            gnt_idx;
    logic [NREQ-1:0] gnt_oh;

    // Grant selection. A held lock wins only while its owner still requests; otherwise the
    // search starts at ptr in the same cycle, so a dropped lock costs no idle cycle.
    always_comb begin : grant_sel
        idx_t cand;
        cand      = '0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        if (rst_n) begin
            if (lock_act_q && bus.req_valid[lock_own_q]) begin
                gnt_found = 1'b1;
                gnt_idx   = lock_own_q;
            end else begin
                for (int unsigned k = 0; k < NREQ; k++) begin
                    cand = idx_t'((32'(ptr_q) + k) % NREQ);
                    if (!gnt_found && bus.req_valid[cand]) begin
                        gnt_found = 1'b1;
                        gnt_idx   = cand;
                    end
                end
            end
        end
        gnt_oh = gnt_found ? ({{(NREQ-1){1'b0}}, 1'b1} << gnt_idx) : '0;
    end

    always_comb begin : outputs
        bus.req_ready = gnt_oh;
        bus.ram_wen   = 1'b0;
        bus.ram_addr  = '0;
        bus.ram_wdata = '0;
        if (gnt_found) begin
            bus.ram_wen   = bus.req_wen[gnt_idx];
            bus.ram_addr  = bus.req_addr[int'(gnt_idx)*10 +: 10];
            bus.ram_wdata = bus.req_wdata[int'(gnt_idx)*18 +: 18];
        end
        bus.rsp_valid = rsp_pend_q;
        // RAM output is already registered, so data is passed straight through.
        bus.rsp_data  = bus.ram_rdata;
    end

    always_comb begin : next_state
        ptr_d      = ptr_q;
        lock_own_d = lock_own_q;
        // With no grant the lock is either unused or its owner dropped valid: release it.
        lock_act_d = 1'b0;
        rsp_pend_d = '0;
        if (gnt_found) begin
            ptr_d      = (gnt_idx == idx_t'(NREQ - 1)) ? '0 : gnt_idx + idx_t'(1);
            lock_own_d = gnt_idx;
            lock_act_d = bus.req_lock[gnt_idx];
            rsp_pend_d = bus.req_wen[gnt_idx] ? '0 : gnt_oh;
        end
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q      <= '0;
            lock_own_q <= '0;
            lock_act_q <= 1'b0;
            rsp_pend_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            lock_own_q <= lock_own_d;
            lock_act_q <= lock_act_d;
            rsp_pend_q <= rsp_pend_d;
        end
    end
endmodule

// File: tb/tb_ram1kx18_arb.sv
// tb_ram1kx18_arb: directed self-checking bench for ram1kx18_arb (NREQ = 3) with a
// behavioural 1Kx18 RAM (registered read) preloaded with mem[a] = 0x100 + 7*a.
module tb_ram1kx18_arb;
    localparam int unsigned NREQ = 3;

    logic mclk;
    logic rst_n;
    int   nchecks;
    int   nerrors;

    ram1kx18_arb_if #(.NREQ(NREQ)) bus ();

    ram1kx18_arb #(.NREQ(NREQ)) dut (
        .mclk  (mclk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    logic [17:0] mem [1024];
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 18'h100 + 18'(i * 7);
    end
    always @(posedge mclk) begin
        if (bus.ram_wen) mem[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_rdata <= mem[bus.ram_addr];
    end

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [9:0] a, input logic [17:0] d);
        bus.req_addr[i*10 +: 10]  = a;
        bus.req_wdata[i*18 +: 18] = d;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.req_valid = 3'b111;
        bus.req_wen   = 3'b111;
        bus.req_lock  = 3'b000;
        set_req(0, 10'h011, 18'h3FFFF);
        set_req(1, 10'h022, 18'h12345);
        set_req(2, 10'h033, 18'h2AAAA);
        repeat (2) @(posedge mclk);
        #1;
        nchecks++;
        if (bus.req_ready !== 3'b000) begin
            nerrors++; $display("FAIL reset_ready: got %b want 000", bus.req_ready);
        end
        nchecks++;
        if (bus.ram_wen !== 1'b0) begin
            nerrors++; $display("FAIL reset_ram_wen: got %b want 0", bus.ram_wen);
        end
        nchecks++;
        if (bus.ram_addr !== 10'h000 || bus.ram_wdata !== 18'h00000) begin
            nerrors++;
            $display("FAIL reset_ram_bus: got addr %h data %h want 000 00000",
                     bus.ram_addr, bus.ram_wdata);
        end
        nchecks++;
        if (bus.rsp_valid !== 3'b000) begin
            nerrors++; $display("FAIL reset_rsp_valid: got %b want 000", bus.rsp_valid);
        end
        rst_n       = 1'b1;
        bus.req_wen = 3'b000;
        #1;
        nchecks++;
        if (bus.req_ready !== 3'b001) begin
            nerrors++; $display("FAIL reset_first_grant: got %b want 001", bus.req_ready);
        end
        bus.req_valid = 3'b000;
        #1;
    endtask

    task automatic test_round_robin();
        logic [9:0]  exp_addr [3];
        logic [17:0] exp_data [3];
        logic [2:0]  exp_oh;
        exp_addr = '{10'd10, 10'd20, 10'd30};
        exp_data = '{18'h00146, 18'h0018C, 18'h001D2};
        set_req(0, 10'd10, 18'h0);
        set_req(1, 10'd20, 18'h0);
        set_req(2, 10'd30, 18'h0);
        bus.req_wen   = 3'b000;
        bus.req_lock  = 3'b000;
        bus.req_valid = 3'b111;
        #1;
        for (int c = 0; c < 6; c++) begin
            exp_oh = 3'(1 << (c % 3));
            nchecks++;
            if (bus.req_ready !== exp_oh || bus.ram_addr !== exp_addr[c % 3]) begin
                nerrors++;
                $display("FAIL rr_grant[%0d]: got ready %b addr %0d want %b %0d", c,
                         bus.req_ready, bus.ram_addr, exp_oh, exp_addr[c % 3]);
            end
            if (c > 0) begin
                exp_oh = 3'(1 << ((c - 1) % 3));
                nchecks++;
                if (bus.rsp_valid !== exp_oh || bus.rsp_data !== exp_data[(c - 1) % 3]) begin
                    nerrors++;
                    $display("FAIL rr_rsp[%0d]: got valid %b data %h want %b %h", c,
                             bus.rsp_valid, bus.rsp_data, exp_oh, exp_data[(c - 1) % 3]);
                end
            end
            tick();
        end
        bus.req_valid = 3'b000;
        #1;
        nchecks++;
        if (bus.rsp_valid !== 3'b100 || bus.rsp_data !== 18'h001D2) begin
            nerrors++;
            $display("FAIL rr_last_rsp: got valid %b data %h want 100 001d2",
                     bus.rsp_valid, bus.rsp_data);
        end
        tick();
        nchecks++;
        if (bus.rsp_valid !== 3'b000) begin
            nerrors++; $display("FAIL rr_rsp_idle: got %b want 000", bus.rsp_valid);
        end
    endtask

    task automatic test_write_read();
        set_req(1, 10'h3FF, 18'h2ABCD);
        bus.req_wen   = 3'b010;
        bus.req_valid = 3'b010;
        #1;
        nchecks++;
        if (bus.req_ready !== 3'b010 || bus.ram_wen !== 1'b1 || bus.ram_addr !== 10'h3FF ||
            bus.ram_wdata !== 18'h2ABCD) begin
            nerrors++;
            $display("FAIL wr_drive: got ready %b wen %b addr %h data %h want 010 1 3ff 2abcd",
                     bus.req_ready, bus.ram_wen, bus.ram_addr, bus.ram_wdata);
        end
        tick();
        bus.req_wen = 3'b000;
        #1;
        nchecks++;
        if (bus.req_ready !== 3'b010 || bus.ram_wen !== 1'b0 || bus.rsp_valid !== 3'b000) begin
            nerrors++;
            $display("FAIL rd_drive: got ready %b wen %b rsp_valid %b want 010 0 000",
                     bus.req_ready, bus.ram_wen, bus.rsp_valid);
        end
        tick();
        nchecks++;
        if (bus.rsp_valid !== 3'b010 || bus.rsp_data !== 18'h2ABCD) begin
            nerrors++;
            $display("FAIL wr_rd_rsp: got valid %b data %h want 010 2abcd",
                     bus.rsp_valid, bus.rsp_data);
        end
        bus.req_valid = 3'b000;
        #1;
    endtask

    task automatic test_lock_burst();
        set_req(0, 10'd10, 18'h0);
        set_req(1, 10'd20, 18'h0);
        set_req(2, 10'd30, 18'h0);
        bus.req_wen   = 3'b000;
        bus.req_valid = 3'b111;
        for (int k = 0; k < 4; k++) begin
            bus.req_lock = (k < 3) ? 3'b100 : 3'b000;
            #1;
            nchecks++;
            if (bus.req_ready !== 3'b100) begin
                nerrors++;
                $display("FAIL lock_grant[%0d]: got %b want 100", k, bus.req_ready);
            end
            if (k > 0) begin
                nchecks++;
                if (bus.rsp_valid !== 3'b100 || bus.rsp_data !== 18'h001D2) begin
                    nerrors++;
                    $display("FAIL lock_rsp[%0d]: got valid %b data %h want 100 001d2", k,
                             bus.rsp_valid, bus.rsp_data);
                end
            end
            tick();
        end
        bus.req_lock = 3'b000;
        #1;
        nchecks++;
        if (bus.req_ready !== 3'b001 || bus.rsp_valid !== 3'b100) begin
            nerrors++;
            $display("FAIL lock_release: got ready %b rsp_valid %b want 001 100",
                     bus.req_ready, bus.rsp_valid);
        end
        bus.req_valid = 3'b000;
        #1;
    endtask

    task automatic test_lock_drop();
        set_req(0, 10'd40, 18'h00155);
        bus.req_wen   = 3'b001;
        bus.req_lock  = 3'b001;
        bus.req_valid = 3'b111;
        #1;
        nchecks++;
        if (bus.req_ready !== 3'b001 || bus.ram_wen !== 1'b1) begin
            nerrors++;
            $display("FAIL drop_wr_grant: got ready %b wen %b want 001 1",
                     bus.req_ready, bus.ram_wen);
        end
        tick();
        bus.req_wen = 3'b000;
        #1;
        nchecks++;
        if (bus.req_ready !== 3'b001 || bus.ram_addr !== 10'd40) begin
            nerrors++;
            $display("FAIL drop_wr_lock_held: got ready %b addr %0d want 001 40",
                     bus.req_ready, bus.ram_addr);
        end
        tick();
        bus.req_valid = 3'b110;
        #1;
        nchecks++;
        if (bus.req_ready !== 3'b010 || bus.ram_addr !== 10'd20) begin
            nerrors++;
            $display("FAIL drop_next_grant: got ready %b addr %0d want 010 20",
                     bus.req_ready, bus.ram_addr);
        end
        nchecks++;
        if (bus.rsp_valid !== 3'b001 || bus.rsp_data !== 18'h00155) begin
            nerrors++;
            $display("FAIL drop_rsp0: got valid %b data %h want 001 00155",
                     bus.rsp_valid, bus.rsp_data);
        end
        tick();
        bus.req_lock  = 3'b000;
        bus.req_valid = 3'b000;
        #1;
        nchecks++;
        if (bus.rsp_valid !== 3'b010 || bus.rsp_data !== 18'h0018C) begin
            nerrors++;
            $display("FAIL drop_rsp1: got valid %b data %h want 010 0018c",
                     bus.rsp_valid, bus.rsp_data);
        end
    endtask

    task automatic test_reset_mid_read();
        bus.req_wen   = 3'b000;
        bus.req_valid = 3'b100;
        #1;
        nchecks++;
        if (bus.req_ready !== 3'b100) begin
            nerrors++; $display("FAIL midrst_grant: got %b want 100", bus.req_ready);
        end
        #1;
        rst_n = 1'b0;
        #1;
        nchecks++;
        if (bus.req_ready !== 3'b000 || bus.ram_addr !== 10'h000) begin
            nerrors++;
            $display("FAIL midrst_gate: got ready %b addr %h want 000 000",
                     bus.req_ready, bus.ram_addr);
        end
        tick();
        nchecks++;
        if (bus.rsp_valid !== 3'b000) begin
            nerrors++; $display("FAIL midrst_rsp_in: got %b want 000", bus.rsp_valid);
        end
        bus.req_valid = 3'b000;
        tick();
        rst_n = 1'b1;
        #1;
        nchecks++;
        if (bus.rsp_valid !== 3'b000) begin
            nerrors++; $display("FAIL midrst_rsp_rel: got %b want 000", bus.rsp_valid);
        end
        tick();
        nchecks++;
        if (bus.rsp_valid !== 3'b000) begin
            nerrors++; $display("FAIL midrst_rsp_after: got %b want 000", bus.rsp_valid);
        end
        bus.req_valid = 3'b111;
        #1;
        nchecks++;
        if (bus.req_ready !== 3'b001) begin
            nerrors++; $display("FAIL midrst_ptr: got %b want 001", bus.req_ready);
        end
        bus.req_valid = 3'b000;
        #1;
    endtask

    initial begin
        nchecks       = 0;
        nerrors       = 0;
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_wen   = '0;
        bus.req_lock  = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        test_reset();
        test_round_robin();
        test_write_read();
        test_lock_burst();
        test_lock_drop();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end
endmodule
